alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid / req1_valid  input  1 each  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1 each  arbiter accepts requester N's operation this cycle.
REQ-006 req0_rs1, req0_rs2, req1_rs1, req1_rs2  input  XLEN each  operands.
REQ-007 req0_op / req1_op  input  4 each  ALU opcode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
REQ-008 resp0_valid / resp1_valid  output  1 each  result for requester N is available.
REQ-009 resp0_ready / resp1_ready  input  1 each  requester N consumes its response.
REQ-010 resp_result  output  XLEN  registered ALU result, shared by both response channels.
REQ-011 resp_zero  output  1  registered ALU zero flag.
REQ-012 resp_err  output  1  registered flag: the captured opcode was above 0100.
REQ-013 alu_rs1, alu_rs2  output  XLEN each  operands driven to the shared ALU.
REQ-014 alu_op  output  4  opcode driven to the shared ALU.
REQ-015 alu_result  input  XLEN  combinational ALU result.
REQ-016 alu_zero  input  1  combinational ALU zero flag.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, EXEC and RESP, binary encoded, with reset state IDLE.
REQ-019 In IDLE with no valid request: all ready outputs 0, FSM stays in IDLE.
REQ-020 In IDLE, only one valid requester: its ready SHALL be 1 combinationally in that cycle.
REQ-021 In IDLE, both requesters valid: round-robin grant to the requester not served last; last_grant resets to 1, so requester 0 wins the first contention.
REQ-022 At most one ready SHALL be high in any cycle; ready SHALL be 0 outside IDLE.
REQ-023 On valid&ready: latch rs1, rs2, op and the grant index into internal registers; IDLE->EXEC.
REQ-024 EXEC (1 cycle): alu_rs1/alu_rs2/alu_op driven from the latched registers; capture alu_result->resp_result, alu_zero->resp_zero and (op>0100)->resp_err; EXEC->RESP.
REQ-025 Outside EXEC: alu_rs1, alu_rs2 and alu_op SHALL hold the latched values (no toggling on idle cycles).
REQ-026 RESP: resp<g>_valid=1 for the granted index g only; resp_result/zero/err stable until consumed.
REQ-027 RESP with resp<g>_ready=1: last_grant<=g, RESP->IDLE; the response valid drops in the next cycle.
REQ-028 Readiness of the non-granted requester's response SHALL be ignored.
REQ-029 A new request SHALL NOT be accepted in the cycle a response is consumed; minimum accept-to-accept spacing is 3 cycles.
REQ-030 Latency from accept edge to resp_valid SHALL be 2 cycles.
REQ-031 An illegal opcode SHALL still complete the full handshake, with resp_result = alu_result (0 from the ALU) and resp_err=1.
REQ-032 A requester dropping valid in IDLE before a handshake SHALL NOT be granted in that cycle.

Reset
REQ-033 rst_n low SHALL force the following asynchronously, whatever the FSM state (including EXEC and RESP): FSM=IDLE; last_grant=1; latched operands, opcode and alu_* outputs=0; resp_result=0; resp_zero=0; resp_err=0; resp*_valid=0; busy=0.
REQ-034 Any in-flight operation SHALL be discarded without a response.
REQ-035 After rst_n deasserts, the first request SHALL be accepted on the first clock edge.

Verification
REQ-036 req0 ADD 5+7, resp0_ready=1 -> ready in cycle 0; resp0_valid 2 cycles later with result 12, zero 0, err 0.
REQ-037 Both valid every cycle, SUB 9-9 from both, responses always ready -> grants alternate 0,1,0,1; every result 0 with zero=1.
REQ-038 req1 XOR 0xFFFF_FFFF^0xFFFF_FFFF, resp1_ready held 0 for 4 cycles -> resp1_valid and result 0 held stable; req0 not readied until consumed.
REQ-039 req0 op 1111 -> resp_err=1, result 0, zero=1, FSM returns to IDLE.
REQ-040 Assert rst_n low during EXEC -> all outputs at reset values immediately; no resp_valid after release; next request from either requester is accepted on the first clock edge after release.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared external ALU.
// Round-robin grant, one operation in flight, registered response.
module alu_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    input  logic            req1_valid,
    output logic            req0_ready,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req0_rs1,
    input  logic [XLEN-1:0] req0_rs2,
    input  logic [XLEN-1:0] req1_rs1,
    input  logic [XLEN-1:0] req1_rs2,
    input  logic [3:0]      req0_op,
    input  logic [3:0]      req1_op,
    output logic            resp0_valid,
    output logic            resp1_valid,
    input  logic            resp0_ready,
    input  logic            resp1_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            resp_zero,
    output logic            resp_err,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            last_grant;
    logic            grant_q;
    logic            gnt_sel;
    logic            accept;
    logic            consume;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [3:0]      op_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Grant selection, handshakes and next-state
    always_comb begin
        state_nx    = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        gnt_sel     = 1'b0;
        accept      = 1'b0;
        consume     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0_valid && req1_valid) gnt_sel = ~last_grant;
                else                          gnt_sel = req1_valid;
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    req0_ready = ~gnt_sel;
                    req1_ready = gnt_sel;
                    state_nx   = EXEC;
                end
            end
            EXEC: state_nx = RESP;
            RESP: begin
                resp0_valid = ~grant_q;
                resp1_valid = grant_q;
                consume = grant_q ? resp1_ready : resp0_ready;
                if (consume) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch, result capture and round-robin history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q       <= '0;
            rs2_q       <= '0;
            op_q        <= '0;
            grant_q     <= 1'b0;
            last_grant  <= 1'b1;
            resp_result <= '0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
        end else begin
            if (accept) begin
                rs1_q   <= gnt_sel ? req1_rs1 : req0_rs1;
                rs2_q   <= gnt_sel ? req1_rs2 : req0_rs2;
                op_q    <= gnt_sel ? req1_op  : req0_op;
                grant_q <= gnt_sel;
            end
            if (state == EXEC) begin
                resp_result <= alu_result;
                resp_zero   <= alu_zero;
                resp_err    <= (op_q > 4'd4);
            end
            if (consume) last_grant <= grant_q;
        end
    end

    assign alu_rs1 = rs1_q;
    assign alu_rs2 = rs2_q;
    assign alu_op  = op_q;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU.
// Inputs change on the falling edge; outputs sampled 1ns later.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
    logic [3:0]  req0_op, req1_op;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready, resp1_ready;
    logic [31:0] resp_result;
    logic        resp_zero, resp_err;
    logic [31:0] alu_rs1, alu_rs2;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    alu_arbiter #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
        .req0_op(req0_op), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_zero(resp_zero),
        .resp_err(resp_err),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural shared ALU
    always_comb begin
        case (alu_op)
            4'd0:    alu_result = alu_rs1 + alu_rs2;
            4'd1:    alu_result = alu_rs1 - alu_rs2;
            4'd2:    alu_result = alu_rs1 & alu_rs2;
            4'd3:    alu_result = alu_rs1 | alu_rs2;
            4'd4:    alu_result = alu_rs1 ^ alu_rs2;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0;
        req0_rs1 = 0; req0_rs2 = 0; req0_op = 0;
        req1_rs1 = 0; req1_rs2 = 0; req1_op = 0;
        resp0_ready = 0; resp1_ready = 0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_v0", resp0_valid, 0);
        check("rst_v1", resp1_valid, 0);
        check("rst_res", resp_result, 0);
        check("rst_alu_rs1", alu_rs1, 0);
        check("rst_alu_op", alu_op, 0);

        // ADD 5+7 on req0, presented with reset release
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1; req0_op = 4'd0;
        req0_rs1 = 32'd5; req0_rs2 = 32'd7;
        resp0_ready = 1;
        #1;
        check("add_rdy0", req0_ready, 1);
        check("add_rdy1", req1_ready, 0);
        check("add_busy0", busy, 0);
        @(negedge clk);
        req0_valid = 0;
        #1;
        check("add_exec_busy", busy, 1);
        check("add_exec_v0", resp0_valid, 0);
        check("add_exec_rdy0", req0_ready, 0);
        check("add_alu_rs1", alu_rs1, 5);
        check("add_alu_rs2", alu_rs2, 7);
        settle();
        check("add_v0", resp0_valid, 1);
        check("add_v1", resp1_valid, 0);
        check("add_res", resp_result, 12);
        check("add_zero", resp_zero, 0);
        check("add_err", resp_err, 0);
        settle();
        check("add_done_v0", resp0_valid, 0);
        check("add_done_busy", busy, 0);
        check("add_hold_rs1", alu_rs1, 5);

        // Contention: SUB 9-9 from both, grants alternate from 0
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req0_valid = 1; req1_valid = 1;
        req0_op = 4'd1; req1_op = 4'd1;
        req0_rs1 = 9; req0_rs2 = 9;
        req1_rs1 = 9; req1_rs2 = 9;
        resp0_ready = 1; resp1_ready = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr%0d_rdy0", i), req0_ready, (i % 2 == 0));
            check($sformatf("rr%0d_rdy1", i), req1_ready, (i % 2 == 1));
            settle();
            check($sformatf("rr%0d_exec_rdy", i),
                  {req0_ready, req1_ready}, 0);
            settle();
            check($sformatf("rr%0d_v0", i), resp0_valid, (i % 2 == 0));
            check($sformatf("rr%0d_v1", i), resp1_valid, (i % 2 == 1));
            check($sformatf("rr%0d_res", i), resp_result, 0);
            check($sformatf("rr%0d_zero", i), resp_zero, 1);
            check($sformatf("rr%0d_resp_rdy", i),
                  {req0_ready, req1_ready}, 0);
            settle();
        end

        // req1 XOR with stalled response; req0 waits
        req0_valid = 0;
        req1_valid = 1; req1_op = 4'd4;
        req1_rs1 = 32'hFFFF_FFFF; req1_rs2 = 32'hFFFF_FFFF;
        resp1_ready = 0; resp0_ready = 1;
        #1;
        check("xor_rdy1", req1_ready, 1);
        check("xor_rdy0", req0_ready, 0);
        @(negedge clk);
        req1_valid = 0;
        req0_valid = 1; req0_op = 4'd0;
        req0_rs1 = 1; req0_rs2 = 2;
        #1;
        check("xor_exec_rdy0", req0_ready, 0);
        for (int k = 0; k < 4; k++) begin
            settle();
            check($sformatf("stall%0d_v1", k), resp1_valid, 1);
            check($sformatf("stall%0d_v0", k), resp0_valid, 0);
            check($sformatf("stall%0d_res", k), resp_result, 0);
            check($sformatf("stall%0d_zero", k), resp_zero, 1);
            check($sformatf("stall%0d_rdy0", k), req0_ready, 0);
        end
        resp1_ready = 1;
        settle();
        check("stall_done_v1", resp1_valid, 0);
        check("stall_rdy0", req0_ready, 1);
        @(negedge clk);
        req0_valid = 0;
        #1;
        check("add2_alu_rs1", alu_rs1, 1);
        settle();
        check("add2_v0", resp0_valid, 1);
        check("add2_res", resp_result, 3);

        // Illegal opcode on req0
        @(negedge clk);
        req0_valid = 1; req0_op = 4'hF;
        req0_rs1 = 3; req0_rs2 = 4;
        #1;
        check("ill_rdy0", req0_ready, 1);
        @(negedge clk);
        req0_valid = 0;
        settle();
        check("ill_v0", resp0_valid, 1);
        check("ill_err", resp_err, 1);
        check("ill_res", resp_result, 0);
        check("ill_zero", resp_zero, 1);
        settle();
        check("ill_idle", busy, 0);
        check("ill_v0_drop", resp0_valid, 0);

        // Reset during EXEC
        req1_valid = 1; req1_op = 4'd2;
        req1_rs1 = 32'hF0F0; req1_rs2 = 32'hFF00;
        #1;
        check("and_rdy1", req1_ready, 1);
        @(negedge clk);
        req1_valid = 0;
        #1;
        check("and_exec_busy", busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_v1", resp1_valid, 0);
        check("ar_res", resp_result, 0);
        check("ar_err", resp_err, 0);
        check("ar_zero", resp_zero, 0);
        check("ar_alu_rs1", alu_rs1, 0);
        check("ar_alu_rs2", alu_rs2, 0);
        check("ar_alu_op", alu_op, 0);
        settle();
        check("ar_hold_v1", resp1_valid, 0);
        check("ar_hold_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req1_valid = 1; req1_op = 4'd3;
        req1_rs1 = 32'hA0; req1_rs2 = 32'h05;
        #1;
        check("post_rdy1", req1_ready, 1);
        @(negedge clk);
        req1_valid = 0;
        #1;
        check("post_busy", busy, 1);
        check("post_exec_v1", resp1_valid, 0);
        settle();
        check("post_v1", resp1_valid, 1);
        check("post_res", resp_result, 32'hA5);
        settle();
        check("post_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
